count_display_2d: RTL and testbench

COUNT_DISPLAY_2D -- requirements
Module: count_display_2d

---
 rtl/count_display_2d.sv | 142 ++++++++++++++
 tb/tb_count_display_2d.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/count_display_2d.sv
// count_display_2d
// Converts a 7-bit binary count (saturated at 99) to two BCD digits with a
// three-state double-dabble FSM, and multiplexes them onto a two-digit,
// active-low seven-segment display.
//
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous active-high reset
//   count_in  [6:0] binary count to display
//   bcd_out   [7:0] registered BCD of last conversion ([7:4] tens, [3:0] ones)
//   done      one-cycle pulse when bcd_out updates
//   seg       [6:0] active-low segments {g,f,e,d,c,b,a}
//   an        [1:0] active-low digit enables (an[0] ones, an[1] tens)
//
// Parameter REFRESH_DIV: clk cycles each digit stays lit (2..2^20).
// Optional macro LEADING_ZERO_BLANK_EN: blank the tens digit when it is zero.
//
// state | meaning
// IDLE  | compare count_in with last_val, start a conversion on change
// SHIFT | seven add-3/shift iterations, then one hand-over cycle
// DONE  | latch scratch into bcd_out and pulse done
module count_display_2d #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] count_in,
    output logic [7:0] bcd_out,
    output logic       done,
    output logic [6:0] seg,
    output logic [1:0] an
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state;
    logic [6:0]  last_val;
    logic [6:0]  bin;
    logic [7:0]  scratch;
    logic [7:0]  adj;
    logic [2:0]  iter;

    logic [CW-1:0] refresh_cnt;
    logic          sel;
    logic          sel_next;
    logic [6:0]    ones_seg;
    logic [6:0]    tens_seg;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'h40;
            4'd1:    seg_decode = 7'h79;
            4'd2:    seg_decode = 7'h24;
            4'd3:    seg_decode = 7'h30;
            4'd4:    seg_decode = 7'h19;
            4'd5:    seg_decode = 7'h12;
            4'd6:    seg_decode = 7'h02;
            4'd7:    seg_decode = 7'h78;
            4'd8:    seg_decode = 7'h00;
            4'd9:    seg_decode = 7'h10;
            default: seg_decode = 7'h7F;
        endcase
    endfunction

    // Double-dabble correction: a nibble >= 5 would overflow past 9 once doubled.
    always_comb begin
        adj = scratch;
        if (scratch[3:0] >= 4'd5) adj[3:0] = scratch[3:0] + 4'd3;
        if (scratch[7:4] >= 4'd5) adj[7:4] = scratch[7:4] + 4'd3;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            last_val <= '0;
            bin      <= '0;
            scratch  <= '0;
            iter     <= '0;
            bcd_out  <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (count_in != last_val) begin
                        bin      <= (count_in > 7'd99) ? 7'd99 : count_in;
                        last_val <= count_in;
                        scratch  <= '0;
                        iter     <= '0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Iterations run while iter is 0..6; the cycle that sees
                    // iter==7 only hands over to DONE, giving 9-edge latency.
                    if (iter == 3'd7) begin
                        state <= DONE;
                    end else begin
                        scratch <= {adj[6:0], bin[6]};
                        bin     <= {bin[5:0], 1'b0};
                        iter    <= iter + 3'd1;
                    end
                end
                DONE: begin
                    bcd_out <= scratch;
                    done    <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Display path reads only bcd_out, never the conversion scratch.
    always_comb begin
        sel_next = (refresh_cnt == CNT_LAST) ? ~sel : sel;
        ones_seg = seg_decode(bcd_out[3:0]);
`ifdef LEADING_ZERO_BLANK_EN
        tens_seg = (bcd_out[7:4] == 4'd0) ? 7'h7F : seg_decode(bcd_out[7:4]);
`else
        tens_seg = seg_decode(bcd_out[7:4]);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt <= '0;
            sel         <= 1'b0;
            an          <= 2'b10;
            seg         <= 7'h40;
        end else begin
            refresh_cnt <= (refresh_cnt == CNT_LAST) ? '0 : refresh_cnt + 1'b1;
            sel         <= sel_next;
            an          <= sel_next ? 2'b01 : 2'b10;
            seg         <= sel_next ? tens_seg : ones_seg;
        end
    end

endmodule

// File: tb/tb_count_display_2d.sv
// tb_count_display_2d
// Self-checking bench for count_display_2d with REFRESH_DIV=4.
// Expected BCD values come from a vector table and are queued when a count is
// driven, then popped when done pulses.
module tb_count_display_2d;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] count_in;
    logic [7:0] bcd_out;
    logic       done;
    logic [6:0] seg;
    logic [1:0] an;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];
    logic [6:0] segtab[10];
    logic mon_en = 1'b0;
    logic prev_done = 1'b0;

    typedef struct {
        logic [6:0] cin;
        logic [7:0] bcd;
    } vec_t;
    vec_t vecs[11];

    count_display_2d #(.REFRESH_DIV(4)) dut (
        .clk(clk), .reset(reset), .count_in(count_in),
        .bcd_out(bcd_out), .done(done), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // an must never enable both digits; done must never last two cycles.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("an_never_00", {31'd0, an == 2'b00}, 32'd0);
            if (prev_done) chk("done_one_cycle", {31'd0, done}, 32'd0);
            prev_done = done;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count edges until done is seen, check latency, pop and compare result.
    task automatic wait_done(input string name, input int exp_edges);
        int n;
        logic [7:0] e;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done === 1'b1) begin
                n = i;
                break;
            end
        end
        if (n == 0) begin
            chk({name, "_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({name, "_latency"}, n, exp_edges);
            if (exp_q.size() == 0) begin
                chk({name, "_unexpected_done"}, 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk({name, "_bcd"}, bcd_out, e);
            end
        end
    endtask

    task automatic check_display(input string name, input logic [7:0] bcd);
        logic [6:0] s_ones, s_tens, e_tens;
        logic got_o, got_t;
        got_o = 1'b0;
        got_t = 1'b0;
        s_ones = '0;
        s_tens = '0;
        repeat (10) tick();
        for (int i = 0; i < 12; i++) begin
            tick();
            if (an == 2'b10) begin s_ones = seg; got_o = 1'b1; end
            if (an == 2'b01) begin s_tens = seg; got_t = 1'b1; end
        end
`ifdef LEADING_ZERO_BLANK_EN
        e_tens = (bcd[7:4] == 4'd0) ? 7'h7F : segtab[bcd[7:4]];
`else
        e_tens = segtab[bcd[7:4]];
`endif
        chk({name, "_ones_seen"}, {31'd0, got_o}, 32'd1);
        chk({name, "_tens_seen"}, {31'd0, got_t}, 32'd1);
        chk({name, "_ones_seg"}, s_ones, segtab[bcd[3:0]]);
        chk({name, "_tens_seg"}, s_tens, e_tens);
    endtask

    initial begin
        int pulses;
        int chg[$];
        logic [1:0] prev_an;

        segtab[0] = 7'h40; segtab[1] = 7'h79; segtab[2] = 7'h24; segtab[3] = 7'h30;
        segtab[4] = 7'h19; segtab[5] = 7'h12; segtab[6] = 7'h02; segtab[7] = 7'h78;
        segtab[8] = 7'h00; segtab[9] = 7'h10;

        vecs[0]  = '{7'd57,  8'h57};
        vecs[1]  = '{7'd115, 8'h99};
        vecs[2]  = '{7'd0,   8'h00};
        vecs[3]  = '{7'd99,  8'h99};
        vecs[4]  = '{7'd100, 8'h99};
        vecs[5]  = '{7'd127, 8'h99};
        vecs[6]  = '{7'd9,   8'h09};
        vecs[7]  = '{7'd10,  8'h10};
        vecs[8]  = '{7'd7,   8'h07};
        vecs[9]  = '{7'd1,   8'h01};
        vecs[10] = '{7'd42,  8'h42};

        // Reset for one cycle with count_in=0.
        reset = 1'b1;
        count_in = 7'd0;
        tick();
        chk("rst_bcd", bcd_out, 8'h00);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_an", an, 2'b10);
        chk("rst_seg", seg, 7'h40);
        reset = 1'b0;
        mon_en = 1'b1;
        pulses = 0;
        repeat (15) begin
            tick();
            if (done === 1'b1) pulses++;
        end
        chk("zero_no_done", pulses, 0);

        // Table: drive, queue expectation, done on 10th edge after driving
        // (9th after the sampling edge), then check both display slots.
        for (int k = 0; k < 11; k++) begin
            count_in = vecs[k].cin;
            exp_q.push_back(vecs[k].bcd);
            wait_done($sformatf("vec%0d", k), 10);
            check_display($sformatf("disp%0d", k), vecs[k].bcd);
        end

        // Unchanged input: no new conversion.
        pulses = 0;
        repeat (15) begin
            tick();
            if (done === 1'b1) pulses++;
        end
        chk("same_no_done", pulses, 0);

        // Digit select period: an toggles every 4 cycles.
        prev_an = an;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (an != prev_an) chg.push_back(i);
            prev_an = an;
        end
        chk("an_changes", {31'd0, chg.size() >= 3}, 32'd1);
        if (chg.size() >= 3) begin
            chk("an_period_a", chg[1] - chg[0], 4);
            chk("an_period_b", chg[2] - chg[1], 4);
        end

        // Input changes during the 3rd SHIFT cycle are ignored, then picked up.
        count_in = 7'd12;
        exp_q.push_back(8'h12);
        repeat (3) tick();
        count_in = 7'd34;
        exp_q.push_back(8'h34);
        wait_done("mid_first", 7);
        wait_done("mid_second", 10);

        // Reset mid-SHIFT discards the conversion, restarts after release.
        count_in = 7'd88;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        chk("midrst_bcd", bcd_out, 8'h00);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_an", an, 2'b10);
        chk("midrst_seg", seg, 7'h40);
        reset = 1'b0;
        exp_q.push_back(8'h88);
        wait_done("post_rst", 10);
        check_display("disp_88", 8'h88);

        chk("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
